// File: rtl/muldiv_unit.sv
// Purpose : iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Latency : XLEN+2 cycles start->done, 1 cycle for divide-by-zero/overflow, 3 for fast multiply.
// Backpr. : no queueing; start is only honoured in IDLE, busy stalls the pipeline meanwhile.
// Option  : define MULDIV_FAST_MUL_EN for a single-cycle registered multiplier path.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t              state;
    logic [2:0]          f3;
    logic                neg_a;
    logic                neg_b;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [CW-1:0]       cnt;
    // Multiply: full product. Divide: low half holds the dividend shifting out / quotient shifting in.
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     res_q;

    logic                sgn_a_en;
    logic                sgn_b_en;
    logic                in_neg_a;
    logic                in_neg_b;
    logic [XLEN-1:0]     in_mag_a;
    logic [XLEN-1:0]     in_mag_b;
    logic                div0;
    logic                ovf;
    logic                spec_hit;
    logic [XLEN-1:0]     spec_res;

    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;

    logic [2*XLEN-1:0]   prod_neg;
    logic [XLEN-1:0]     rem_neg;
    logic                neg_q;
    logic [XLEN-1:0]     fix_res;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a;
    logic signed [XLEN:0]     fast_b;
    logic signed [2*XLEN+1:0] fast_p;

    // Magnitudes are non-negative, so zero-extending into the signed XLEN+1 operands is exact.
    always_comb begin
        fast_a = $signed({1'b0, mag_a});
        fast_b = $signed({1'b0, mag_b});
        fast_p = fast_a * fast_b;
    end
`endif

    // Decode operand signedness, magnitudes and the divide special cases straight from the inputs.
    always_comb begin
        sgn_a_en = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b_en = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        in_neg_a = sgn_a_en & op_a[XLEN-1];
        in_neg_b = sgn_b_en & op_b[XLEN-1];
        in_mag_a = in_neg_a ? -op_a : op_a;
        in_mag_b = in_neg_b ? -op_b : op_b;
        div0     = (op_b == '0);
        ovf      = funct3[2] & ~funct3[0] & (op_a == MIN_NEG) & (op_b == '1);
        spec_hit = funct3[2] & (div0 | ovf);
        spec_res = '0;
        if (div0) begin
            spec_res = funct3[1] ? op_a : '1;
        end else if (ovf) begin
            spec_res = funct3[1] ? '0 : op_a;
        end
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? mag_a : {XLEN{1'b0}})};
        div_shift = {rem, prod[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b};
    end

    // Sign correction and selection of the architectural result.
    always_comb begin
        neg_q    = neg_a ^ neg_b;
        prod_neg = -prod;
        rem_neg  = -rem;
        fix_res  = '0;
        case (f3)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = neg_q ? prod_neg[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = neg_q ? prod_neg[XLEN-1:0] : prod[XLEN-1:0];
            default:                fix_res = neg_a ? rem_neg : rem;
        endcase
    end

    // Control FSM together with all datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            f3     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            cnt    <= '0;
            prod   <= '0;
            rem    <= '0;
            res_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        f3    <= funct3;
                        neg_a <= in_neg_a;
                        neg_b <= in_neg_b;
                        mag_a <= in_mag_a;
                        mag_b <= in_mag_b;
                        cnt   <= '0;
                        rem   <= '0;
                        if (spec_hit) begin
                            res_q <= spec_res;
                            state <= S_FIN;
                        end else begin
                            // Multiplier sits in the low half; dividend likewise for divides.
                            prod  <= funct3[2] ? {{XLEN{1'b0}}, in_mag_a} : {{XLEN{1'b0}}, in_mag_b};
                            busy  <= 1'b1;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
`ifdef MULDIV_FAST_MUL_EN
                    if (!f3[2]) begin
                        prod  <= fast_p[2*XLEN-1:0];
                        state <= S_FIX;
                    end else
`endif
                    begin
                        if (!f3[2]) begin
                            prod <= {mul_sum, prod[XLEN-1:1]};
                        end else if (!div_diff[XLEN]) begin
                            rem             <= div_diff[XLEN-1:0];
                            prod[XLEN-1:0]  <= {prod[XLEN-2:0], 1'b1};
                        end else begin
                            rem             <= div_shift[XLEN-1:0];
                            prod[XLEN-1:0]  <= {prod[XLEN-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    res_q <= fix_res;
                    busy  <= 1'b0;
                    state <= S_FIN;
                end
                S_FIN: begin
                    result <= res_q;
                    done   <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a scoreboard queue holds expected results, popped on done.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    localparam int LAT_DIV  = 34;
    localparam int LAT_SPEC = 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL  = 3;
`else
    localparam int LAT_MUL  = 34;
`endif

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op, optionally re-pulse start mid-op, then compare against the scoreboard.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit repulse);
        int          cyc;
        bit          got;
        logic [31:0] want;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        got   = 1'b0;
        while (!got && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (repulse && cyc == 10) begin
                start  = 1'b1;
                funct3 = 3'b000;
                op_a   = 32'd3;
                op_b   = 32'd5;
            end
            if (repulse && cyc == 11) start = 1'b0;
            if (cyc == 1) check({tag, "_busy_mid"}, {31'd0, busy}, {31'd0, lat > 1});
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            check({tag, "_latency"}, cyc, lat);
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                check({tag, "_queue"}, exp_q.size(), 1);
            end else begin
                want = exp_q.pop_front();
                check({tag, "_result"}, result, want);
                @(negedge clk);
                check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
                check({tag, "_result_hold"}, result, want);
            end
        end
    endtask

    initial begin
        int cyc;
        bit seen;
        reset  = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;

        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_MUL, 1'b0);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL, 1'b0);
        run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT_MUL, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, LAT_MUL, 1'b0);
        run_op("mulh_mn",3'b001, 32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL, 1'b0);
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_DIV, 1'b0);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_DIV, 1'b0);
        run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       LAT_DIV, 1'b0);
        run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        LAT_DIV, 1'b0);
        run_op("div_big",3'b101, 32'hFFFFFFFF, 32'h80000000, 32'd1,        LAT_DIV, 1'b0);
        run_op("div0",   3'b100, 32'd1234,     32'd0,        32'hFFFFFFFF, LAT_SPEC, 1'b0);
        run_op("remu0",  3'b111, 32'd5,        32'd0,        32'd5,        LAT_SPEC, 1'b0);
        run_op("div_ovf",3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SPEC, 1'b0);
        run_op("rem_ovf",3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_SPEC, 1'b0);
        run_op("repulse",3'b101, 32'd1000,     32'd9,        32'd111,      LAT_DIV, 1'b1);

        // Abort an op with reset at cycle 5; no done may follow.
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b100;
        op_a   = 32'd50;
        op_b   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 5; i++) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy_after", {31'd0, busy}, 32'd0);
        check("abort_result",     result, 32'd0);
        seen = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);

        run_op("post_reset", 3'b110, 32'd50, 32'hFFFFFFFD, 32'd2, LAT_DIV, 1'b0);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
